// File: rtl/ad9634_spi_pkg.sv
// rtl/ad9634_spi_pkg.sv - shared constants and state encoding for the AD9634-style SPI responder
// Contents: frame geometry (address/data widths, frame length, R/W bit position)
//           and the responder state enum.
package ad9634_spi_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int FRAME_BITS = 24;
  localparam int RW_BIT     = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    TAIL
  } spi_state_e;

endpackage

// File: rtl/ad9634_spi_sync.sv
// rtl/ad9634_spi_sync.sv - multi-flop synchronizer with rise/fall detect for one bit
// Ports: clk_i, rst_n_i (sync active-low), d_i (async input),
//        q_o (synchronized level), rise_o / fall_o (one-cycle edge pulses).
module ad9634_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // Reset loads the idle level into every stage so no false edge follows reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q_o    = chain[STAGES-1];
  assign rise_o = q_o & ~q_d;
  assign fall_o = ~q_o & q_d;

endmodule

// File: rtl/ad9634_spi_slave.sv
// rtl/ad9634_spi_slave.sv - oversampled SPI responder with a local 16-bit register file
// Ports: clk_i, rst_n_i (sync active-low); SCLK_i, CS_N_i, MOSI_i from the master;
//        MISO_o, MISO_oe_o to the master; wr_strobe_o/wr_addr_o/wr_data_o commit report;
//        rd_strobe_o read-frame completion; lcl_addr_i/lcl_data_o fabric read port;
//        busy_o frame in progress.
module ad9634_spi_slave
  import ad9634_spi_pkg::*;
#(
  parameter int REG_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        SCLK_i,
  input  logic        CS_N_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  output logic        MISO_oe_o,
  output logic        wr_strobe_o,
  output logic [6:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        rd_strobe_o,
  input  logic [6:0]  lcl_addr_i,
  output logic [15:0] lcl_data_o,
  output logic        busy_o
);

  localparam int         IDX_W   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(REG_DEPTH);

  // Synchronized inputs and edges; the *_unused names mark edges nobody consumes.
  logic sclk_s, sclk_rise, sclk_fall_unused;
  logic cs_n_s, cs_rise_unused, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  ad9634_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(SCLK_i),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );
  ad9634_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(CS_N_i),
    .q_o(cs_n_s), .rise_o(cs_rise_unused), .fall_o(cs_fall)
  );
  ad9634_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(MOSI_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e  state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [14:0] shift;       // only the low 15 bits are ever needed with the live MOSI bit
  logic [6:0]  addr_idx;
  logic [14:0] rd_shift;    // bits still to be presented on MISO after bit 15
  logic [15:0] regs [REG_DEPTH];

  logic [7:0]  addr_word;
  logic [15:0] data_word;
  logic [15:0] ld_data;
  logic [15:0] lcl_rd;
  logic        wr_in_range;
  logic        sclk_unused;

  // Control decoded by the FSM for the datapath.
  logic start, addr_done, wr_commit, rd_next, rd_done, abort;

  assign addr_word   = {shift[6:0], mosi_s};
  assign data_word   = {shift[14:0], mosi_s};
  assign wr_in_range = ({1'b0, addr_idx} < DEPTH_L);
  assign busy_o      = (state != IDLE);
  assign sclk_unused = sclk_s;

  always_comb begin
    ld_data = '0;
    if ({1'b0, addr_word[6:0]} < DEPTH_L) ld_data = regs[addr_word[IDX_W-1:0]];
  end

  always_comb begin
    lcl_rd = '0;
    if ({1'b0, lcl_addr_i} < DEPTH_L) lcl_rd = regs[lcl_addr_i[IDX_W-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // CS_N high in any active state other than TAIL is an abort; it wins over a
  // simultaneous SCLK rise so a truncated frame can never commit.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    addr_done = 1'b0;
    wr_commit = 1'b0;
    rd_next   = 1'b0;
    rd_done   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start     = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (cs_n_s) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 5'(ADDR_W - 1)) begin
          addr_done = 1'b1;
          state_nxt = addr_word[RW_BIT] ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (cs_n_s) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise && bit_cnt == 5'(FRAME_BITS - 1)) begin
          wr_commit = 1'b1;
          state_nxt = TAIL;
        end
      end
      RDATA: begin
        if (cs_n_s) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          if (bit_cnt == 5'(FRAME_BITS - 1)) begin
            rd_done   = 1'b1;
            state_nxt = TAIL;
          end else begin
            rd_next = 1'b1;
          end
        end
      end
      TAIL: begin
        if (cs_n_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bit_cnt     <= '0;
      shift       <= '0;
      addr_idx    <= '0;
      rd_shift    <= '0;
      MISO_o      <= 1'b0;
      MISO_oe_o   <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      rd_strobe_o <= 1'b0;
      lcl_data_o  <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      lcl_data_o  <= lcl_rd;

      if (start) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (sclk_rise && !cs_n_s &&
                   (state == ADDR || state == WDATA || state == RDATA)) begin
        shift   <= {shift[13:0], mosi_s};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (addr_done) begin
        addr_idx <= addr_word[6:0];
        if (!addr_word[RW_BIT]) begin
          rd_shift  <= ld_data[14:0];
          MISO_o    <= ld_data[15];
          MISO_oe_o <= 1'b1;
        end
      end

      if (wr_commit && wr_in_range) begin
        regs[addr_idx[IDX_W-1:0]] <= data_word;
        wr_strobe_o <= 1'b1;
        wr_addr_o   <= addr_idx;
        wr_data_o   <= data_word;
      end

      if (rd_next) begin
        MISO_o   <= rd_shift[14];
        rd_shift <= {rd_shift[13:0], 1'b0};
      end

      if (rd_done) rd_strobe_o <= 1'b1;

      if (rd_done || abort) begin
        MISO_o    <= 1'b0;
        MISO_oe_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad9634_spi_slave.sv
// tb/tb_ad9634_spi_slave.sv - directed self-checking bench for ad9634_spi_slave
module tb_ad9634_spi_slave;

  localparam int HALF = 6;   // clk_i cycles per SCLK phase

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic        wr_strobe, rd_strobe, busy;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [6:0]  lcl_addr = '0;
  logic [15:0] lcl_data;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [6:0]  last_wa = '0;
  logic [15:0] last_wd = '0;
  logic [15:0] exp_regs [16];

  logic [15:0] dout;
  logic        oe_ok, busy4, busy_mid;

  always #5 clk = ~clk;

  ad9634_spi_slave dut (
    .clk_i(clk), .rst_n_i(rst_n), .SCLK_i(sclk), .CS_N_i(cs_n), .MOSI_i(mosi),
    .MISO_o(miso), .MISO_oe_o(miso_oe), .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .rd_strobe_o(rd_strobe), .lcl_addr_i(lcl_addr),
    .lcl_data_o(lcl_data), .busy_o(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_strobe) rd_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int idx);
    lcl_addr = 7'(idx);
    wait_clk(1);
    chk($sformatf("lcl_data[%0d]", idx), {16'h0, lcl_data}, {16'h0, exp_regs[idx]});
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) check_reg(i);
  endtask

  // One master frame; nbits SCLK pulses, optional 1-cycle reset after rise rst_at.
  task automatic spi_xfer(input logic [7:0] a, input logic [15:0] d, input int nbits,
                          input int rst_at, output logic [15:0] rdat,
                          output logic oe_good, output logic b4, output logic bmid);
    logic [23:0] word;
    logic        dropped;
    logic        exp_oe;
    word    = {a, d};
    dropped = 1'b0;
    rdat    = '0;
    oe_good = 1'b1;
    bmid    = 1'b0;
    cs_n    = 1'b0;
    wait_clk(HALF);
    for (int r = 1; r <= nbits; r++) begin
      if (!dropped) begin
        mosi = (r <= 24) ? word[24-r] : 1'b0;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
        exp_oe = !a[7] && r >= 8 && r <= 23;
        if (miso_oe !== exp_oe) oe_good = 1'b0;
        if (!a[7] && r >= 8 && r <= 23) rdat[23-r] = miso;
        if (r == 1) bmid = busy;
        sclk = 1'b0;
        if (r == rst_at) begin
          wait_clk(1);
          rst_n = 1'b0;
          wait_clk(1);
          rst_n = 1'b1;
          cs_n  = 1'b1;
          dropped = 1'b1;
        end
      end
    end
    if (!dropped) begin
      wait_clk(HALF);
      cs_n = 1'b1;
    end
    wait_clk(4);
    b4 = busy;
    wait_clk(6);
    mosi = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;

    // Reset state
    wait_clk(3);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("rst miso", {31'h0, miso}, 32'h0);
    chk("rst wr_strobe", {31'h0, wr_strobe}, 32'h0);
    chk("rst wr_data", {16'h0, wr_data}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);
    check_reg(0);

    // Write 0x85 <- A5C3
    spi_xfer(8'h85, 16'hA5C3, 24, 0, dout, oe_ok, busy4, busy_mid);
    exp_regs[5] = 16'hA5C3;
    chk("wr85 count", wr_cnt, 1);
    chk("wr85 addr", {25'h0, last_wa}, 32'h05);
    chk("wr85 data", {16'h0, last_wd}, 32'hA5C3);
    chk("wr85 busy mid", {31'h0, busy_mid}, 32'h1);
    chk("wr85 busy after", {31'h0, busy4}, 32'h0);
    chk("wr85 oe", {31'h0, oe_ok}, 32'h1);
    check_reg(5);

    // Boundary in-range indices 0 and 15
    spi_xfer(8'h80, 16'h0001, 24, 0, dout, oe_ok, busy4, busy_mid);
    exp_regs[0] = 16'h0001;
    spi_xfer(8'h8F, 16'h8000, 24, 0, dout, oe_ok, busy4, busy_mid);
    exp_regs[15] = 16'h8000;
    chk("wr8F count", wr_cnt, 3);
    chk("wr8F addr", {25'h0, last_wa}, 32'h0F);

    // Read back
    spi_xfer(8'h05, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("rd05 dout", {16'h0, dout}, 32'hA5C3);
    chk("rd05 strobe count", rd_cnt, 1);
    chk("rd05 oe window", {31'h0, oe_ok}, 32'h1);
    chk("rd05 miso idle", {31'h0, miso}, 32'h0);
    chk("rd05 oe idle", {31'h0, miso_oe}, 32'h0);
    spi_xfer(8'h0F, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("rd0F dout", {16'h0, dout}, 32'h8000);
    chk("rd0F oe window", {31'h0, oe_ok}, 32'h1);
    spi_xfer(8'h00, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("rd00 dout", {16'h0, dout}, 32'h0001);

    // Out-of-range write and reads
    spi_xfer(8'h9F, 16'h1234, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("wr9F no strobe", wr_cnt, 3);
    check_all();
    spi_xfer(8'h1F, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("rd1F dout", {16'h0, dout}, 32'h0);
    spi_xfer(8'h10, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("rd10 dout", {16'h0, dout}, 32'h0);
    chk("rd oor strobes", rd_cnt, 5);

    // Abort after 14 rises of a write to 0x82
    spi_xfer(8'h82, 16'hBEEF, 14, 0, dout, oe_ok, busy4, busy_mid);
    chk("abort no strobe", wr_cnt, 3);
    chk("abort busy", {31'h0, busy4}, 32'h0);
    chk("abort oe", {31'h0, miso_oe}, 32'h0);
    check_reg(2);

    // Long frame: 4 extra SCLK pulses after 24
    spi_xfer(8'h83, 16'hFFFF, 28, 0, dout, oe_ok, busy4, busy_mid);
    exp_regs[3] = 16'hFFFF;
    chk("long count", wr_cnt, 4);
    chk("long data", {16'h0, last_wd}, 32'hFFFF);
    chk("long addr", {25'h0, last_wa}, 32'h03);
    chk("long idle", {31'h0, busy4}, 32'h0);
    check_reg(3);

    // Reset during bit 12 of a read
    spi_xfer(8'h05, 16'h0000, 24, 12, dout, oe_ok, busy4, busy_mid);
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    chk("rstmid oe", {31'h0, miso_oe}, 32'h0);
    chk("rstmid busy", {31'h0, busy}, 32'h0);
    chk("rstmid miso", {31'h0, miso}, 32'h0);
    chk("rstmid no rd strobe", rd_cnt, 5);
    check_all();

    // Recovery frame pair
    spi_xfer(8'h8A, 16'h5A5A, 24, 0, dout, oe_ok, busy4, busy_mid);
    exp_regs[10] = 16'h5A5A;
    chk("post wr count", wr_cnt, 5);
    chk("post wr data", {16'h0, last_wd}, 32'h5A5A);
    spi_xfer(8'h0A, 16'h0000, 24, 0, dout, oe_ok, busy4, busy_mid);
    chk("post rd dout", {16'h0, dout}, 32'h5A5A);
    chk("post rd strobe", rd_cnt, 6);
    check_reg(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad9634_spi_slave.md
Name: ad9634_spi_slave

Overview:
- SPI responder for the 24-bit AD9634-style frame: 8-bit address word, then 16-bit data word, MSB first.
- Address bit 7 = 1 is a write; 0 is a read.
- Holds a local 16-bit register file that the SPI master can write and read back.
- Two uses:
  - FPGA-side ADC register model for loop-back verification of the SPI master.
  - Slave port on a bridge where an external controller configures fabric registers.
- SCLK, CS_N and MOSI are oversampled in the clk_i domain; no logic is clocked by SCLK.

Parameters:
- REG_DEPTH, 16: number of 16-bit registers; index = address bits [6:0].
- SYNC_STAGES, 2: synchronizer flops on SCLK_i, CS_N_i and MOSI_i (minimum 2).

Ports:
- clk_i  in  1  system clock; at least 8x SCLK frequency.
- rst_n_i  in  1  synchronous active-low reset.
- SCLK_i  in  1  SPI clock from master; idles low.
- CS_N_i  in  1  SPI chip select, active low.
- MOSI_i  in  1  SPI data from master; master changes it while SCLK is low.
- MISO_o  out  1  SPI data to master.
- MISO_oe_o  out  1  high while this block drives MISO (read data phase).
- wr_strobe_o  out  1  one-cycle pulse when an SPI write commits.
- wr_addr_o  out  7  register index of the committed write.
- wr_data_o  out  16  data of the committed write.
- rd_strobe_o  out  1  one-cycle pulse when a read frame's 16 data bits have been shifted out.
- lcl_addr_i  in  7  fabric-side read index.
- lcl_data_o  out  16  fabric-side read data, registered, 1-cycle latency.
- busy_o  out  1  high from CS_N falling until return to IDLE.

Behaviour:
- Reset is synchronous on rst_n_i low:
  - Register file and all outputs return to 0, except busy_o = 0 and MISO_oe_o = 0.
  - Synchronizers are cleared to the idle pattern: SCLK 0, CS_N 1.
  - A reset during a frame drops the frame; no write commits.
- Edge detection runs on the synchronized signals. Detect rise and fall of SCLK and the fall of CS_N; the synchronized value is compared with its one-cycle-delayed copy.
- bit_cnt counts 0..24 and increments on each SCLK rise while CS_N is low. MOSI is sampled into the shift register on each SCLK rise.
- State machine:
  - IDLE:
    - On CS_N fall: clear bit_cnt and the shifter, set busy_o, go to ADDR.
  - ADDR:
    - After the 8th rise, latch the address.
    - If addr[7] = 1, go to WDATA.
    - Otherwise go to RDATA. In the same cycle, load the read shifter from reg[addr[6:0]], drive MISO_o with bit 15 and set MISO_oe_o.
  - WDATA:
    - After the 24th rise, and if addr[6:0] < REG_DEPTH: write reg, pulse wr_strobe_o, drive wr_addr_o/wr_data_o.
    - Out-of-range writes are dropped with no strobe.
    - Go to TAIL.
  - RDATA:
    - On rises 9..23, shift the next bit to MISO_o, so bit 15-k follows rise 8+k.
    - After the 24th rise, pulse rd_strobe_o, drive MISO_o = 0, clear MISO_oe_o, go to TAIL.
    - Out-of-range reads return 0x0000.
  - TAIL:
    - Ignore further SCLK edges.
    - Return to IDLE when CS_N is high, clearing busy_o.
- Latency from a physical SCLK rise to MISO_o update is SYNC_STAGES+1 clk_i cycles. The master samples on the following SCLK fall, so the SCLK high phase must be at least SYNC_STAGES+2 clk_i cycles.
- A CS_N rise in any state other than TAIL aborts the frame:
  - No write, no strobes.
  - MISO_o = 0, MISO_oe_o = 0, go to IDLE.
- A CS_N fall while in TAIL is only acted on after a return to IDLE. The frame's first rise therefore must not precede IDLE re-entry.
- The fabric read port always reads the register file, including during frames.
- If an SPI write and a lcl_addr_i read hit the same index in the same cycle, lcl_data_o returns the old value.
- An RDATA load and a WDATA commit cannot coincide, because there is a single frame at a time.

Decomposition:
- Shared package ad9634_spi_pkg holds:
  - ADDR_W = 8, DATA_W = 16, FRAME_BITS = 24, RW_BIT = 7.
  - State enum {IDLE, ADDR, WDATA, RDATA, TAIL}.
- Sub-module ad9634_spi_sync: SYNC_STAGES synchronizer plus rise/fall detect for one bit, instanced three times.

Test Plan:
- Loop-back: the existing SPI master (NO_OF_CLKS = 10, clk shared) writes addr 0x85 with data 0xA5C3 -> wr_strobe_o pulses once, wr_addr_o = 0x05, wr_data_o = 0xA5C3, lcl_addr_i = 5 gives lcl_data_o = 0xA5C3.
- Loop-back read: master reads addr 0x05 -> master dout = 0xA5C3, rd_strobe_o pulses once, MISO_oe_o high only across rises 8..24.
- Out-of-range: write 0x9F with data 0x1234 (index 31 ≥ 16) -> no wr_strobe_o, all regs unchanged. Read 0x1F -> master dout = 0x0000.
- Abort: CS_N raised after 14 SCLK rises of a write to 0x82 -> no strobe, reg[2] unchanged, busy_o low within 4 cycles, MISO_oe_o = 0.
- Long frame: write 0x83 with 0xFFFF followed by 4 extra SCLK pulses before CS_N rises -> exactly one write of 0xFFFF, then IDLE on the CS_N rise.
- Reset mid-read: rst_n_i low for 1 cycle during bit 12 of a read -> MISO_oe_o = 0, busy_o = 0, all regs 0. The next full write/read frame then works.
